// File: rtl/pipeline_hazard_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pipeline_hazard_ctrl_if
// Brief    : Pipe-status inputs and enable/flush/forwarding outputs of the
//            hazard controller.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] ex_rs;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  ex_mem_read;
    logic [REG_ADDR_W-1:0] ex_dst;
    logic                  ex_mul_start;
    logic                  mem_reg_write;
    logic                  wb_reg_write;
    logic [REG_ADDR_W-1:0] mem_dst;
    logic [REG_ADDR_W-1:0] wb_dst;
    logic                  take_branch;
    logic                  counter_clear;

    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic                  pc_en;
    logic                  if_id_en;
    logic                  id_ex_en;
    logic                  ex_mem_en;
    logic                  if_id_flush;
    logic                  id_ex_flush;
    logic                  ex_mem_flush;
    logic                  mul_busy;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_events;

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_mem_read,
               ex_dst, ex_mul_start, mem_reg_write, wb_reg_write, mem_dst,
               wb_dst, take_branch, counter_clear,
        input  fwd_a, fwd_b, pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush,
               id_ex_flush, ex_mem_flush, mul_busy, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rs, ex_rt, ex_mem_read,
               ex_dst, ex_mul_start, mem_reg_write, wb_reg_write, mem_dst,
               wb_dst, take_branch, counter_clear,
        output fwd_a, fwd_b, pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush,
               id_ex_flush, ex_mem_flush, mul_busy, stall_cycles, flush_events
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : pipeline_hazard_ctrl
// Brief    : Forwarding, load-use stall, branch flush, multi-cycle EX stall
//            and saturating stall/flush counters for the 5-stage core.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_W   = 5,
    parameter int MUL_LATENCY  = 4,
    parameter int BRANCH_FLUSH = 3,
    parameter int CNT_W        = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz
);
    localparam int c_MUL_CNT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;
    localparam logic [c_MUL_CNT_W-1:0] c_MUL_RELOAD =
        c_MUL_CNT_W'((MUL_LATENCY > 2) ? MUL_LATENCY - 2 : 0);
    // Bit 0 = IF/ID, bit 1 = ID/EX, bit 2 = EX/MEM.
    localparam logic [2:0] c_BRANCH_MASK = 3'((1 << BRANCH_FLUSH) - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;
    localparam bit c_MUL_MULTI = (MUL_LATENCY > 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [c_MUL_CNT_W-1:0] r_cnt;
    logic [c_MUL_CNT_W-1:0] w_cntNext;
    logic [CNT_W-1:0]       r_stallCycles;
    logic [CNT_W-1:0]       r_flushEvents;

    logic       w_loadUse;
    logic       w_mulStart;
    logic       w_mulStall;
    logic [1:0] w_fwdA;
    logic [1:0] w_fwdB;
    logic [3:0] w_en;     // {pc, if_id, id_ex, ex_mem}
    logic [2:0] w_flush;  // {ex_mem, id_ex, if_id}
    logic       w_busy;

    function automatic logic [1:0] fwdSel(
        input logic [REG_ADDR_W-1:0] src,
        input logic                  memWr,
        input logic [REG_ADDR_W-1:0] memDst,
        input logic                  wbWr,
        input logic [REG_ADDR_W-1:0] wbDst
    );
        if (memWr && (memDst != '0) && (memDst == src)) begin
            return 2'b10;
        end else if (wbWr && (wbDst != '0) && (wbDst == src)) begin
            return 2'b11;
        end
        return 2'b00;
    endfunction

    always_comb begin
        w_loadUse  = hz.ex_mem_read && (hz.ex_dst != '0) &&
                     ((hz.id_uses_rs && (hz.ex_dst == hz.id_rs)) ||
                      (hz.id_uses_rt && (hz.ex_dst == hz.id_rt)));
        w_mulStart = (r_state == ST_IDLE) && hz.ex_mul_start && c_MUL_MULTI;
        w_mulStall = w_mulStart || ((r_state == ST_BUSY) && (r_cnt != '0));
    end

    // Output decode: branch outranks the multi-cycle stall, which outranks load-use.
    always_comb begin
        w_fwdA  = fwdSel(hz.ex_rs, hz.mem_reg_write, hz.mem_dst, hz.wb_reg_write, hz.wb_dst);
        w_fwdB  = fwdSel(hz.ex_rt, hz.mem_reg_write, hz.mem_dst, hz.wb_reg_write, hz.wb_dst);
        w_en    = 4'b1111;
        w_flush = 3'b000;
        w_busy  = (r_state == ST_BUSY);
        if (reset) begin
            w_fwdA  = 2'b00;
            w_fwdB  = 2'b00;
            w_flush = 3'b111;
            w_busy  = 1'b0;
        end else if (hz.take_branch) begin
            w_flush = c_BRANCH_MASK;
        end else if (w_mulStall) begin
            w_en    = 4'b0001;
            w_flush = 3'b100;
        end else if (w_loadUse) begin
            w_en    = 4'b0011;
            w_flush = 3'b010;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        if (hz.take_branch) begin
            w_stateNext = ST_IDLE;
            w_cntNext   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mulStart) begin
                        w_stateNext = ST_BUSY;
                        w_cntNext   = c_MUL_RELOAD;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != '0) begin
                        w_cntNext = r_cnt - c_MUL_CNT_W'(1);
                    end else begin
                        w_stateNext = ST_IDLE;
                    end
                end
                default: w_stateNext = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || hz.counter_clear) begin
            r_stallCycles <= '0;
            r_flushEvents <= '0;
        end else begin
            if (!w_en[3] && (r_stallCycles != c_CNT_MAX)) begin
                r_stallCycles <= r_stallCycles + CNT_W'(1);
            end
            if (hz.take_branch && (r_flushEvents != c_CNT_MAX)) begin
                r_flushEvents <= r_flushEvents + CNT_W'(1);
            end
        end
    end

    assign hz.fwd_a        = w_fwdA;
    assign hz.fwd_b        = w_fwdB;
    assign hz.pc_en        = w_en[3];
    assign hz.if_id_en     = w_en[2];
    assign hz.id_ex_en     = w_en[1];
    assign hz.ex_mem_en    = w_en[0];
    assign hz.if_id_flush  = w_flush[0];
    assign hz.id_ex_flush  = w_flush[1];
    assign hz.ex_mem_flush = w_flush[2];
    assign hz.mul_busy     = w_busy;
    assign hz.stall_cycles = r_stallCycles;
    assign hz.flush_events = r_flushEvents;
endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Parametrised hazard controller for the 5-stage pipelined MIPS core. It adds four things to the existing two-source forwarding:
- load-use stall detection;
- branch/jump/JR flush of younger stages;
- a multi-cycle EX-op stall FSM, for multiply/divide of configurable latency;
- saturating stall and flush performance counters.

It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipes and drives their enable and flush inputs plus the forwarding mux selects.

## Interface
- REG_ADDR_W, 5, register-address width
- MUL_LATENCY, 4, EX residency in cycles of a multi-cycle op; must be ≥1
- BRANCH_FLUSH, 3, number of younger pipes flushed on taken branch (1..3, order IF/ID, ID/EX, EX/MEM)
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- id_rs, id_rt  in  REG_ADDR_W  source registers of instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs/rt
- ex_rs, ex_rt  in  REG_ADDR_W  source registers in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_dst  in  REG_ADDR_W  EX destination (after RegDst mux)
- ex_mul_start  in  1  EX instruction is multi-cycle
- mem_reg_write, wb_reg_write  in  1  RegWrite in MEM/WB
- mem_dst, wb_dst  in  REG_ADDR_W  destination in MEM/WB
- take_branch  in  1  MEM-stage redirect (taken beq/bne, j, jal, jr)
- counter_clear  in  1  synchronous clear of both counters
- fwd_a, fwd_b  out  2  00 regfile/EX pipe, 10 MEM ALU result, 11 WB write data
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1  pipe/PC enables
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  load bubble (zero) into pipe
- mul_busy  out  1  FSM in BUSY
- stall_cycles, flush_events  out  CNT_W  performance counters

## Operation
- **Forwarding (combinational).**
  - fwd_a = 10 if mem_reg_write & mem_dst≠0 & mem_dst==ex_rs.
  - Otherwise fwd_a = 11 if wb_reg_write & wb_dst≠0 & wb_dst==ex_rs.
  - Otherwise fwd_a = 00.
  - fwd_b is identical using ex_rt.
  - MEM has priority over WB. Register 0 is never forwarded.
- **Load-use.** Condition: ex_mem_read & ex_dst≠0 & ((id_uses_rs & ex_dst==id_rs) | (id_uses_rt & ex_dst==id_rt)). Response: pc_en=0, if_id_en=0, id_ex_flush=1.
- **Multi-cycle FSM.** States IDLE and BUSY, with a down-counter cnt.
  - IDLE & ex_mul_start & MUL_LATENCY>1: stall this cycle; cnt←MUL_LATENCY−2; state←BUSY.
  - BUSY & cnt>0: stall; cnt←cnt−1.
  - BUSY & cnt==0: no stall; state←IDLE.
  - ex_mul_start is ignored in BUSY.
  - Stall means pc_en=if_id_en=id_ex_en=0 and ex_mem_flush=1 (bubble to MEM); ex_mem_en stays 1.
  - Total stall cycles = MUL_LATENCY−1. With MUL_LATENCY=1 the FSM never stalls.
- **Branch.** On take_branch, flush the first BRANCH_FLUSH pipes (IF/ID, ID/EX, EX/MEM order). pc_en=1. The FSM forces IDLE, which aborts a multi-cycle op younger than the branch.
- **Priority.** take_branch > multi-cycle stall > load-use. A load-use hazard during a multi-cycle stall is deferred: ID/EX is held, so it is re-evaluated after the stall.
- **Counters.**
  - stall_cycles increments on every cycle with pc_en==0.
  - flush_events increments on every take_branch cycle.
  - Both saturate at 2^CNT_W−1.
  - counter_clear has priority over increment.

## Timing
- Forwarding, enable and flush outputs are combinational from inputs and FSM state, with no added latency.
- The FSM and counters update on the rising clk edge.
- While reset=1:
  - outputs: fwd 00, all enables 1, all flushes 1, mul_busy 0;
  - next-state: state←IDLE, cnt←0, counters←0.
- The first cycle after reset deassertion sees IDLE with counters 0.
- Reset mid-BUSY returns to IDLE at that edge. No residual stall.
- take_branch and ex_mul_start in the same IDLE cycle: branch wins, no BUSY entry, no stall.
- mul_busy mirrors the registered state and asserts the cycle after acceptance.

## Test plan
- **Forwarding:** mem_dst=wb_dst=ex_rs=5, both RegWrite=1 → fwd_a=10. Then mem_reg_write=0 → fwd_a=11. Then ex_rs=0 with dsts 0 → fwd_a=00.
- **Load-use:** ex_mem_read=1, ex_dst=8, id_rt=8, id_uses_rt=1 → one cycle of pc_en=0, if_id_en=0, id_ex_flush=1, and stall_cycles 0→1. With id_uses_rt=0 → no stall.
- **Multi-cycle with MUL_LATENCY=4:** pulse ex_mul_start in IDLE → exactly 3 stall cycles with ex_mem_flush=1; mul_busy high for cycles 2–4; stall_cycles=3. MUL_LATENCY=1 → zero stalls.
- **Branch abort:** take_branch in the 2nd BUSY cycle → stall drops immediately; all 3 flushes=1; IDLE next cycle; flush_events=1.
- **Simultaneous events:** take_branch plus load-use plus ex_mul_start in IDLE → only the flushes assert, pc_en=1, no BUSY entry.
- **Reset and counters:** reset asserted mid-BUSY → IDLE and both counters=0 next cycle. Counter preloaded near saturation (CNT_W=4, 15 stalls) → holds at 15. counter_clear with a concurrent stall → 0.
